// File: rtl/cache_pkg.sv
// Shared cache definitions: block geometry, counter width and the
// memory responder FSM states.
package cache_pkg;

    localparam int CNT_BITS = 4;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ_WAIT,
        RESPOND
    } resp_state_t;

    function automatic int block_size(input int block_bits);
        return 1 << block_bits;
    endfunction

endpackage

// File: rtl/block_mem_responder_mem_array.sv
// Word storage with a block-wide synchronous write port and a block-wide
// combinational read port; contents start out as word[a] = a.
module mem_array #(
    parameter int ADDR_BITS  = 10,
    parameter int DATA_BITS  = 32,
    parameter int BLOCK_SIZE = 4
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_base,
    input  logic [DATA_BITS-1:0] wr_data [BLOCK_SIZE],
    input  logic [ADDR_BITS-1:0] rd_base,
    output logic [DATA_BITS-1:0] rd_data [BLOCK_SIZE]
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS-1:0] OFF_MASK = ADDR_BITS'(BLOCK_SIZE - 1);

    typedef logic [DATA_BITS-1:0] mem_t [DEPTH];

    function automatic mem_t init_mem();
        mem_t m;
        for (int a = 0; a < DEPTH; a++) begin
            m[a] = DATA_BITS'(a);
        end
        return m;
    endfunction

    mem_t mem = init_mem();

    // Offset bits are forced to the word index, so a block never straddles
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < BLOCK_SIZE; i++) begin
                mem[(wr_base & ~OFF_MASK) | ADDR_BITS'(i)] <= wr_data[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            rd_data[i] = mem[(rd_base & ~OFF_MASK) | ADDR_BITS'(i)];
        end
    end

endmodule

// File: rtl/block_mem_responder.sv
// Block-granular memory model answering cache fills and write-backs
// with fixed read and write latencies.
module block_mem_responder
    import cache_pkg::*;
#(
    parameter int RAM_ADDRESS_BITS = 10,
    parameter int DATA_BITS        = 32,
    parameter int BLOCK_BITS       = 2,
    parameter int READ_LATENCY     = 4,
    parameter int WRITE_LATENCY    = 3,
    localparam int BLOCK_SIZE      = block_size(BLOCK_BITS)
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        req_valid,
    input  logic [RAM_ADDRESS_BITS-1:0] req_address,
    input  logic                        req_read_en,
    input  logic                        req_write_en,
    input  logic [DATA_BITS-1:0]        req_write_data [BLOCK_SIZE],
    output logic                        ready,
    output logic                        mem_valid,
    output logic [DATA_BITS-1:0]        mem_data [BLOCK_SIZE],
    output logic                        wr_ack,
    output logic                        proto_err
);

    if (READ_LATENCY < 2 || READ_LATENCY > 15) begin : g_bad_rd_lat
        $error("READ_LATENCY must be within 2..15");
    end
    if (WRITE_LATENCY < 1 || WRITE_LATENCY > 15) begin : g_bad_wr_lat
        $error("WRITE_LATENCY must be within 1..15");
    end

    localparam logic [RAM_ADDRESS_BITS-1:0] OFF_MASK =
        RAM_ADDRESS_BITS'(BLOCK_SIZE - 1);
    localparam logic [CNT_BITS-1:0] RD_LOAD = CNT_BITS'(READ_LATENCY - 2);
    localparam logic [CNT_BITS-1:0] WR_LOAD = CNT_BITS'(WRITE_LATENCY - 1);

    resp_state_t                 state_q, state_d;
    logic [CNT_BITS-1:0]         cnt_q, cnt_d;
    logic [RAM_ADDRESS_BITS-1:0] base_q;
    logic [DATA_BITS-1:0]        wdata_q [BLOCK_SIZE];
    logic [DATA_BITS-1:0]        rd_data [BLOCK_SIZE];
    logic                        accept;
    logic                        commit;
    logic                        fill;
    logic                        proto_set;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        accept    = 1'b0;
        commit    = 1'b0;
        fill      = 1'b0;
        proto_set = 1'b0;
        ready     = 1'b0;
        mem_valid = 1'b0;
        wr_ack    = 1'b0;
        unique case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (req_valid) begin
                    // A request flagged as both read and write is a write
                    if (req_write_en) begin
                        accept    = 1'b1;
                        proto_set = req_read_en;
                        cnt_d     = WR_LOAD;
                        state_d   = WRITE;
                    end else if (req_read_en) begin
                        accept  = 1'b1;
                        cnt_d   = RD_LOAD;
                        state_d = READ_WAIT;
                    end else begin
                        proto_set = 1'b1;
                    end
                end
            end
            WRITE: begin
                commit = (cnt_q == WR_LOAD);
                if (cnt_q == '0) begin
                    wr_ack  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            READ_WAIT: begin
                if (cnt_q == '0) begin
                    fill    = 1'b1;
                    state_d = RESPOND;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESPOND: begin
                mem_valid = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            proto_err <= 1'b0;
            for (int i = 0; i < BLOCK_SIZE; i++) begin
                mem_data[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (proto_set) begin
                proto_err <= 1'b1;
            end
            if (fill) begin
                mem_data <= rd_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            base_q  <= req_address & ~OFF_MASK;
            wdata_q <= req_write_data;
        end
    end

    mem_array #(
        .ADDR_BITS  (RAM_ADDRESS_BITS),
        .DATA_BITS  (DATA_BITS),
        .BLOCK_SIZE (BLOCK_SIZE)
    ) u_mem (
        .clk     (clk),
        .wr_en   (commit && reset_n),
        .wr_base (base_q),
        .wr_data (wdata_q),
        .rd_base (base_q),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_block_mem_responder.sv
// Directed bench for block_mem_responder: fill/write-back latencies,
// protocol errors, held requests and reset aborts.
module tb_block_mem_responder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [9:0]  req_address = '0;
    logic        req_read_en = 1'b0;
    logic        req_write_en = 1'b0;
    logic [31:0] req_write_data [4];
    logic        ready;
    logic        mem_valid;
    logic [31:0] mem_data [4];
    logic        wr_ack;
    logic        proto_err;

    int n_cmp = 0;
    int n_err = 0;

    logic [127:0] d1 = {32'hDDDD0004, 32'hCCCC0003,
                        32'hBBBB0002, 32'hAAAA0001};
    logic [127:0] d2 = {32'hE0E0E0E3, 32'hE0E0E0E2,
                        32'hE0E0E0E1, 32'hE0E0E0E0};
    logic [127:0] d3 = {32'h5A5A0003, 32'h5A5A0002,
                        32'h5A5A0001, 32'h5A5A0000};

    always #5 clk = ~clk;

    block_mem_responder dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_address    (req_address),
        .req_read_en    (req_read_en),
        .req_write_en   (req_write_en),
        .req_write_data (req_write_data),
        .ready          (ready),
        .mem_valid      (mem_valid),
        .mem_data       (mem_data),
        .wr_ack         (wr_ack),
        .proto_err      (proto_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_blk(input string tag, input logic [127:0] exp);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s[%0d]", tag, i), mem_data[i], exp[i*32 +: 32]);
        end
    endtask

    function automatic logic [127:0] seq_blk(input logic [9:0] a);
        logic [127:0] b;
        for (int i = 0; i < 4; i++) begin
            b[i*32 +: 32] = (32'(a) & ~32'h3) + 32'(i);
        end
        return b;
    endfunction

    // Presents one request in an idle cycle; returns in cycle T+1
    task automatic issue(input string tag, input logic [9:0] a,
                         input logic rd, input logic wr,
                         input logic [127:0] d);
        chk({tag, "_ready_idle"}, 32'(ready), 32'd1);
        req_valid    = 1'b1;
        req_address  = a;
        req_read_en  = rd;
        req_write_en = wr;
        for (int i = 0; i < 4; i++) req_write_data[i] = d[i*32 +: 32];
        tick();
        req_valid    = 1'b0;
        req_read_en  = 1'b0;
        req_write_en = 1'b0;
    endtask

    // Cycles T+1..T+4 of a fill, then T+5 back in idle
    task automatic read_phase(input string tag, input logic [127:0] exp);
        for (int c = 1; c <= 4; c++) begin
            chk($sformatf("%s_ready_c%0d", tag, c), 32'(ready), 32'd0);
            chk($sformatf("%s_mv_c%0d", tag, c), 32'(mem_valid), 32'(c == 4));
            chk($sformatf("%s_ack_c%0d", tag, c), 32'(wr_ack), 32'd0);
            if (c == 4) chk_blk({tag, "_data"}, exp);
            else tick();
        end
        tick();
        chk({tag, "_ready_after"}, 32'(ready), 32'd1);
        chk({tag, "_mv_after"}, 32'(mem_valid), 32'd0);
        chk_blk({tag, "_held"}, exp);
    endtask

    // Cycles T+1..T+3 of a write-back, then T+4 back in idle
    task automatic write_phase(input string tag);
        for (int c = 1; c <= 3; c++) begin
            chk($sformatf("%s_ready_c%0d", tag, c), 32'(ready), 32'd0);
            chk($sformatf("%s_ack_c%0d", tag, c), 32'(wr_ack), 32'(c == 3));
            chk($sformatf("%s_mv_c%0d", tag, c), 32'(mem_valid), 32'd0);
            if (c < 3) tick();
        end
        tick();
        chk({tag, "_ready_after"}, 32'(ready), 32'd1);
        chk({tag, "_ack_after"}, 32'(wr_ack), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4; i++) req_write_data[i] = '0;
        tick();
        tick();
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_mv", 32'(mem_valid), 32'd0);
        chk("rst_ack", 32'(wr_ack), 32'd0);
        chk("rst_proto", 32'(proto_err), 32'd0);
        chk_blk("rst_data", '0);
        reset_n = 1'b1;
        tick();

        issue("rd010", 10'h010, 1'b1, 1'b0, '0);
        read_phase("rd010", seq_blk(10'h010));

        issue("wr023", 10'h023, 1'b0, 1'b1, d1);
        write_phase("wr023");
        chk_blk("wr023_keep", seq_blk(10'h010));
        issue("rd020", 10'h020, 1'b1, 1'b0, '0);
        read_phase("rd020", d1);
        issue("rd024", 10'h024, 1'b1, 1'b0, '0);
        read_phase("rd024", seq_blk(10'h024));

        issue("both040", 10'h040, 1'b1, 1'b1, d2);
        chk("both_proto", 32'(proto_err), 32'd1);
        write_phase("both040");
        for (int c = 0; c < 3; c++) begin
            chk("both_no_mv", 32'(mem_valid), 32'd0);
            chk("both_proto_sticky", 32'(proto_err), 32'd1);
            tick();
        end
        issue("rd040", 10'h040, 1'b1, 1'b0, '0);
        read_phase("rd040", d2);

        issue("hold1", 10'h100, 1'b1, 1'b0, '0);
        req_valid   = 1'b1;
        req_read_en = 1'b1;
        req_address = 10'h200;
        read_phase("hold1", seq_blk(10'h100));
        tick();
        req_valid   = 1'b0;
        req_read_en = 1'b0;
        read_phase("hold2", seq_blk(10'h200));

        issue("abort_rd", 10'h3FE, 1'b1, 1'b0, '0);
        tick();
        reset_n = 1'b0;
        tick();
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_proto_clr", 32'(proto_err), 32'd0);
        chk("abort_mv", 32'(mem_valid), 32'd0);
        chk_blk("abort_data_clr", '0);
        reset_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            chk("abort_no_mv", 32'(mem_valid), 32'd0);
            tick();
        end
        issue("rd3fc", 10'h3FC, 1'b1, 1'b0, '0);
        read_phase("rd3fc", seq_blk(10'h3FC));

        req_valid   = 1'b1;
        req_address = 10'h008;
        tick();
        req_valid = 1'b0;
        chk("neither_proto", 32'(proto_err), 32'd1);
        chk("neither_ready", 32'(ready), 32'd1);
        for (int c = 0; c < 5; c++) begin
            chk("neither_no_mv", 32'(mem_valid), 32'd0);
            chk("neither_no_ack", 32'(wr_ack), 32'd0);
            tick();
        end
        issue("rd008", 10'h008, 1'b1, 1'b0, '0);
        read_phase("rd008", seq_blk(10'h008));

        issue("wr3fc", 10'h3FD, 1'b0, 1'b1, d3);
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            chk("wr_abort_no_ack", 32'(wr_ack), 32'd0);
            tick();
        end
        issue("rd3fc_b", 10'h3FF, 1'b1, 1'b0, '0);
        read_phase("rd3fc_b", d3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
